// File: rtl/thresh_monitor.sv
// Threshold comparator with registered eq/grt flags, persistence-filtered alarm FSM and saturating rise counter.
// Define THRESH_MONITOR_HYST_EN to require x < thr_q - HYST for alarm release.
module thresh_monitor #(
    parameter int WIDTH        = 8,
    parameter int THRESH_RESET = 159,
    parameter int PERSIST      = 4,
    parameter int CNT_W        = 8,
    parameter int HYST         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x,
    input  logic             thr_load,
    input  logic [WIDTH-1:0] thr_in,
    output logic [WIDTH-1:0] thr_q,
    output logic             eq_result,
    output logic             grt_result,
    output logic             alarm,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] event_count
);

    typedef enum logic {BELOW, ABOVE} state_t;

    localparam logic [7:0]       LP_PERSIST = 8'(PERSIST);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
    localparam logic [WIDTH-1:0] LP_THR_RST = WIDTH'(THRESH_RESET);

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_thr;
    logic             r_eq;
    logic             r_grt;
    logic [7:0]       r_pcnt;
    logic [7:0]       w_pcnt_nx;
    logic             r_pulse;
    logic             w_rise;
    logic [CNT_W-1:0] r_evt;
    logic [CNT_W-1:0] w_evt_nx;
    logic             w_grt;
    logic             w_eq;
    logic             w_rel;
    logic             w_qual;

    assign w_grt = (x > r_thr);
    assign w_eq  = (x == r_thr);

`ifdef THRESH_MONITOR_HYST_EN
    localparam logic [WIDTH-1:0] LP_HYST = WIDTH'(HYST);
    // Saturated limit of zero makes release impossible when thr < HYST
    assign w_rel = (r_thr >= LP_HYST) && (x < (r_thr - LP_HYST));
`else
    assign w_rel = !w_grt;
`endif

    assign w_qual = (r_state == BELOW) ? w_grt : w_rel;

    always_comb begin
        w_state_nx = r_state;
        w_pcnt_nx  = r_pcnt;
        w_rise     = 1'b0;
        w_evt_nx   = r_evt;
        if (thr_load) begin
            w_pcnt_nx = '0;
        end else if (x_valid) begin
            if (!w_qual) begin
                w_pcnt_nx = '0;
            end else if ((r_pcnt + 8'd1) == LP_PERSIST) begin
                w_pcnt_nx = '0;
                unique case (r_state)
                    BELOW: begin
                        w_state_nx = ABOVE;
                        w_rise     = 1'b1;
                        if (r_evt != LP_CNT_MAX)
                            w_evt_nx = r_evt + 1'b1;
                    end
                    ABOVE: w_state_nx = BELOW;
                    default: w_state_nx = BELOW;
                endcase
            end else begin
                w_pcnt_nx = r_pcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BELOW;
            r_thr   <= LP_THR_RST;
            r_eq    <= 1'b0;
            r_grt   <= 1'b0;
            r_pcnt  <= '0;
            r_pulse <= 1'b0;
            r_evt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pcnt  <= w_pcnt_nx;
            r_pulse <= w_rise;
            r_evt   <= w_evt_nx;
            if (thr_load)
                r_thr <= thr_in;
            if (x_valid) begin
                r_eq  <= w_eq;
                r_grt <= w_grt;
            end
        end
    end

    assign thr_q       = r_thr;
    assign eq_result   = r_eq;
    assign grt_result  = r_grt;
    assign alarm       = (r_state == ABOVE);
    assign rise_pulse  = r_pulse;
    assign event_count = r_evt;

endmodule

// File: tb/tb_thresh_monitor.sv
// Scoreboard bench for thresh_monitor: directed vectors push expected outputs,
// a monitor pops and compares one entry per clock edge.
module tb_thresh_monitor;

    logic       clk;
    logic       reset;
    logic       x_valid;
    logic [7:0] x;
    logic       thr_load;
    logic [7:0] thr_in;

    logic [7:0] thr_q,  thr_q2;
    logic       eq_r,   eq_r2;
    logic       grt_r,  grt_r2;
    logic       alarm,  alarm2;
    logic       pulse,  pulse2;
    logic [7:0] evt;
    logic [1:0] evt2;

`ifdef THRESH_MONITOR_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    thresh_monitor u_dut (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x),
        .thr_load(thr_load), .thr_in(thr_in), .thr_q(thr_q),
        .eq_result(eq_r), .grt_result(grt_r), .alarm(alarm),
        .rise_pulse(pulse), .event_count(evt)
    );

    thresh_monitor #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x),
        .thr_load(thr_load), .thr_in(thr_in), .thr_q(thr_q2),
        .eq_result(eq_r2), .grt_result(grt_r2), .alarm(alarm2),
        .rise_pulse(pulse2), .event_count(evt2)
    );

    typedef struct {
        logic       eq;
        logic       grt;
        logic       al;
        logic       pu;
        logic [7:0] ev;
        logic [1:0] ev2;
        logic [7:0] thr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec  = 0;
    int   n_miss = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic chk_all(input exp_t w);
        chk("eq",     32'(eq_r),   32'(w.eq));
        chk("grt",    32'(grt_r),  32'(w.grt));
        chk("alarm",  32'(alarm),  32'(w.al));
        chk("pulse",  32'(pulse),  32'(w.pu));
        chk("events", 32'(evt),    32'(w.ev));
        chk("thr_q",  32'(thr_q),  32'(w.thr));
        chk("alarm2", 32'(alarm2), 32'(w.al));
        chk("pulse2", 32'(pulse2), 32'(w.pu));
        chk("evt2",   32'(evt2),   32'(w.ev2));
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            n_vec++;
            chk_all(e);
        end
    end

    task automatic v(input bit vld, input logic [7:0] xx,
                     input bit ld, input logic [7:0] ti,
                     input bit we, input bit wg, input bit wa,
                     input bit wp, input int wev, input logic [7:0] wth);
        exp_t w;
        @(negedge clk);
        x_valid  = vld;
        x        = xx;
        thr_load = ld;
        thr_in   = ti;
        w.eq  = we;
        w.grt = wg;
        w.al  = wa;
        w.pu  = wp;
        w.ev  = 8'(wev);
        w.ev2 = (wev > 3) ? 2'd3 : 2'(wev);
        w.thr = wth;
        q.push_back(w);
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && q.size() != 0; i++)
            @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        exp_t z;
        reset    = 1'b1;
        x_valid  = 1'b0;
        x        = '0;
        thr_load = 1'b0;
        thr_in   = '0;
        z = '{eq:0, grt:0, al:0, pu:0, ev:0, ev2:0, thr:8'd159};
        #12;
        n_vec++;
        chk_all(z);
        @(negedge clk);
        reset = 1'b0;

        // compare flags and hold
        v(1,159,0,0, 1,0,0,0,0,159);
        v(1,160,0,0, 0,1,0,0,0,159);
        v(1,158,0,0, 0,0,0,0,0,159);
        repeat (3) v(0,200,0,0, 0,0,0,0,0,159);
        // clean rise, pulse one cycle
        repeat (3) v(1,200,0,0, 0,1,0,0,0,159);
        v(1,200,0,0, 0,1,1,1,1,159);
        v(0,0,0,0,   0,1,1,0,1,159);
        repeat (3) v(1,100,0,0, 0,0,1,0,1,159);
        v(1,100,0,0, 0,0,0,0,1,159);
        // broken run
        repeat (3) v(1,200,0,0, 0,1,0,0,1,159);
        v(1,100,0,0, 0,0,0,0,1,159);
        repeat (3) v(1,200,0,0, 0,1,0,0,1,159);
        v(1,200,0,0, 0,1,1,1,2,159);
        repeat (3) v(1,100,0,0, 0,0,1,0,2,159);
        v(1,100,0,0, 0,0,0,0,2,159);
        // idle gaps inside run
        v(1,200,0,0, 0,1,0,0,2,159);
        v(0,200,0,0, 0,1,0,0,2,159);
        v(1,200,0,0, 0,1,0,0,2,159);
        repeat (2) v(0,0,0,0, 0,1,0,0,2,159);
        v(1,200,0,0, 0,1,0,0,2,159);
        v(1,200,0,0, 0,1,1,1,3,159);
        repeat (3) v(1,100,0,0, 0,0,1,0,3,159);
        v(1,100,0,0, 0,0,0,0,3,159);
        // load with same-cycle sample uses old threshold
        v(1,120,1,100, 0,0,0,0,3,100);
        repeat (3) v(1,120,0,0, 0,1,0,0,3,100);
        v(0,0,1,100, 0,1,0,0,3,100);
        repeat (3) v(1,120,0,0, 0,1,0,0,3,100);
        v(1,120,0,0, 0,1,1,1,4,100);
        repeat (3) v(1,50,0,0, 0,0,1,0,4,100);
        v(1,50,0,0, 0,0,0,0,4,100);
        v(0,0,1,159, 0,0,0,0,4,159);
        repeat (3) v(1,200,0,0, 0,1,0,0,4,159);
        v(1,200,0,0, 0,1,1,1,5,159);
        // release band
        repeat (3) v(1,155,0,0, 0,0,1,0,5,159);
        v(1,155,0,0, 0,0,HYST_ON,0,5,159);
        repeat (3) v(1,150,0,0, 0,0,HYST_ON,0,5,159);
        v(1,150,0,0, 0,0,0,0,5,159);
        // partial run then async reset mid-cycle
        v(0,0,1,50, 0,0,0,0,5,50);
        repeat (3) v(1,200,0,0, 0,1,0,0,5,50);
        drain();
        reset = 1'b1;
        #1;
        n_vec++;
        chk_all(z);
        @(negedge clk);
        reset = 1'b0;
        v(1,200,0,0, 0,1,0,0,0,159);
        @(negedge clk);
        x_valid = 1'b0;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/thresh_monitor.md
Name: thresh_monitor

Overview:
- Parametrised successor to the fixed-constant 8-bit comparator. Compares a sampled unsigned input against a run-time programmable threshold.
- Registers the equal and greater-than flags.
- Adds a persistence-filtered alarm state machine and a saturating crossing-event counter.
- Sits between a sensor/datapath sample stream and status/interrupt logic.

Parameters:
- WIDTH, 8: bit width of sample and threshold.
- THRESH_RESET, 159: threshold value loaded on reset.
- PERSIST, 4: consecutive qualifying valid samples required to change alarm state; legal range 1..255.
- CNT_W, 8: width of the event counter.
- HYST, 8: release hysteresis in LSBs; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- x_valid  in  1  sample x is valid this cycle.
- x  in  WIDTH  unsigned sample.
- thr_load  in  1  load thr_in into the threshold register.
- thr_in  in  WIDTH  new threshold value.
- thr_q  out  WIDTH  current threshold.
- eq_result  out  1  last valid sample == threshold.
- grt_result  out  1  last valid sample > threshold.
- alarm  out  1  filtered "above threshold" state.
- rise_pulse  out  1  one-cycle pulse on alarm 0->1.
- event_count  out  CNT_W  number of alarm rising transitions, saturating.

Behaviour:
- Reset values (immediate on reset high, independent of clk): thr_q=THRESH_RESET, eq_result=0, grt_result=0, alarm=0, rise_pulse=0, event_count=0, state=BELOW, persistence counter=0.
- Comparisons are unsigned, full WIDTH.
- Compare flags:
  - On a clk edge with x_valid=1, eq_result and grt_result update from x versus thr_q as it was before that edge. Latency is 1 cycle.
  - With x_valid=0, both flags hold their values.
- Threshold load:
  - On a clk edge with thr_load=1, thr_q <= thr_in.
  - A sample arriving in the same cycle uses the old threshold.
  - The load clears the persistence counter; state and alarm are unchanged.
- Persistence counter: counts only qualifying valid samples. A valid non-qualifying sample clears it. x_valid=0 cycles leave it unchanged.
- State machine:
  - BELOW (alarm=0):
    - Qualifying sample is grt (x > thr_q).
    - When the counter reaches PERSIST, go to ABOVE, set alarm=1, pulse rise_pulse for exactly one cycle, increment event_count, and clear the counter.
  - ABOVE (alarm=1):
    - Qualifying sample is a release sample (see Optional Feature).
    - When the counter reaches PERSIST, go to BELOW, set alarm=0, and clear the counter. There is no pulse on the falling transition.
- Alarm latency: alarm rises on the same edge that registers the PERSIST-th qualifying sample. It is visible in the same cycle as that sample's grt_result.
- PERSIST=1: alarm follows the qualifying sample with 1-cycle latency.
- event_count saturates at 2^CNT_W-1. Further rises still pulse rise_pulse.
- eq sample (x == thr_q) is not grt, so it breaks a rise sequence.
- Reset mid-sequence aborts all progress; no pulse is emitted.

Optional Feature:
- Macro: THRESH_MONITOR_HYST_EN
- Defined: a release sample is x < (thr_q - HYST). The subtraction saturates at 0, so when thr_q < HYST no release is possible except by reset.
- Undefined: a release sample is x <= thr_q (i.e. not grt). The HYST parameter is ignored.
- Compare flags and the rise path are identical in both builds.

Test Plan:
- Reset with defaults -> thr_q=159, all other outputs 0. Assert reset asynchronously mid-cycle -> outputs clear before the next edge.
- x=159 valid -> next cycle eq_result=1, grt_result=0. x=160 -> eq=0, grt=1. x=158 -> both 0. x_valid=0 for 3 cycles -> flags hold.
- Four consecutive valid x=200 -> alarm=1 and rise_pulse=1 on the 4th sample edge; rise_pulse is 0 the next cycle; event_count=1. Sequence 200,200,200,100,200x4 -> alarm rises only after the final 4. Idle gaps inside a run of four 200s -> alarm still rises after the 4th valid sample.
- thr_load=1 with thr_in=100 and x=120 valid in the same cycle -> grt=1 against 159 is false, so grt=0. Next x=120 -> grt=1. Load mid-run of 3 qualifying samples -> counter cleared, 4 more samples needed.
- CNT_W=2: five alarm rise/release cycles -> event_count sticks at 3; rise_pulse still asserted on each rise.
- In ABOVE with thr=159, HYST=8, four x=155 samples:
  - With THRESH_MONITOR_HYST_EN -> alarm stays 1; four x=150 samples then clear it.
  - Without the macro -> alarm clears after the four x=155 samples.
